// File: rtl/icache_direct_mapped_if.sv
// Core-fetch and slow-memory signal bundle for icache_direct_mapped.
// slave = cache side, master = core/memory side.
interface icache_direct_mapped_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: combinational hits, 4-word block refill on miss.
// Optional ICACHE_PERF_CNT_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module icache_direct_mapped #(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  icache_direct_mapped_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0]            hit_cnt_o,
  output logic [15:0]            miss_cnt_o
`endif
);

  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   mem_read_q;
  logic [NUM_BLOCKS-1:0]  valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
  logic [127:0]           data_q [NUM_BLOCKS];

  logic [IDX_W-1:0]       idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic [1:0]             off_s;
  logic [127:0]           line_s;
  logic                   hit_s;
  logic [31:0]            rdata_s;
  logic                   unused_inputs;

  assign idx_s  = bus.proc_addr[IDX_W+1:2];
  assign tag_s  = bus.proc_addr[29:IDX_W+2];
  assign off_s  = bus.proc_addr[1:0];
  assign line_s = data_q[idx_s];
  assign hit_s  = bus.proc_read & valid_q[idx_s] & (tag_q[idx_s] == tag_s);

  assign unused_inputs = bus.proc_write ^ (^bus.proc_wdata);

  // Hit word select; only an IDLE-state hit drives data to the core.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if ((state_q == IDLE) && hit_s) begin
      case (off_s)
        2'd0:    rdata_s = line_s[31:0];
        2'd1:    rdata_s = line_s[63:32];
        2'd2:    rdata_s = line_s[95:64];
        2'd3:    rdata_s = line_s[127:96];
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.proc_rdata = rdata_s;
  assign bus.proc_stall = (state_q != IDLE) | (bus.proc_read & ~hit_s);
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = (state_q == MISS) ? bus.proc_addr[29:2] : 28'h000_0000;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = 128'h0;

  // Refill FSM; mem_read is registered alongside the state so it never glitches.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.proc_read && !hit_s) begin
            state_q    <= MISS;
            mem_read_q <= 1'b1;
          end
        end
        MISS: begin
          // Refill overwrites the indexed line regardless of what it held.
          if (bus.mem_ready) begin
            data_q[idx_s]  <= bus.mem_rdata;
            tag_q[idx_s]   <= tag_s;
            valid_q[idx_s] <= 1'b1;
            state_q        <= FILL;
            mem_read_q     <= 1'b0;
          end
        end
        FILL: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Saturating hit/miss event counters.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_o  <= 16'h0000;
      miss_cnt_o <= 16'h0000;
    end else if (state_q == IDLE) begin
      if (hit_s && (hit_cnt_o != 16'hFFFF)) begin
        hit_cnt_o <= hit_cnt_o + 16'h0001;
      end else begin
        hit_cnt_o <= hit_cnt_o;
      end
      if (bus.proc_read && !hit_s && (miss_cnt_o != 16'hFFFF)) begin
        miss_cnt_o <= miss_cnt_o + 16'h0001;
      end else begin
        miss_cnt_o <= miss_cnt_o;
      end
    end else begin
      hit_cnt_o  <= hit_cnt_o;
      miss_cnt_o <= miss_cnt_o;
    end
  end
`endif

endmodule
